// File: rtl/pipe_pkg.sv
// Shared types and constants for the pipeline control unit: FSM state,
// per-stage register control pair, and stage indices.
package pipe_pkg;

  typedef enum logic {
    RUN      = 1'b0,
    MEM_WAIT = 1'b1
  } ctrl_state_t;

  typedef struct packed {
    logic wr_en;
    logic bubble;
  } stage_ctrl_t;

  localparam int NUM_STAGES = 4;
  localparam int IF_ID      = 0;
  localparam int ID_EX      = 1;
  localparam int EX_MEM     = 2;
  localparam int MEM_WB     = 3;

  localparam stage_ctrl_t STG_ADV  = '{wr_en: 1'b1, bubble: 1'b0};
  localparam stage_ctrl_t STG_HOLD = '{wr_en: 1'b0, bubble: 1'b0};
  localparam stage_ctrl_t STG_BUB  = '{wr_en: 1'b1, bubble: 1'b1};
  localparam stage_ctrl_t STG_RST  = '{wr_en: 1'b0, bubble: 1'b1};

endpackage

// File: rtl/reg_scoreboard.sv
// Pending-write scoreboard: one busy bit per architectural register (x0 excluded),
// set-wins-over-clear, with two combinational read ports.
module reg_scoreboard
  import pipe_pkg::*;
#(
  parameter int NREG  = 32,
  parameter int REG_W = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             set_en,
  input  logic [REG_W-1:0] set_idx,
  input  logic             clr_en,
  input  logic [REG_W-1:0] clr_idx,
  input  logic [REG_W-1:0] rd_idx0,
  input  logic [REG_W-1:0] rd_idx1,
  output logic             hit0,
  output logic             hit1
);

  logic [NREG-1:0] busy;

  assign busy[0] = 1'b0;

  for (genvar g = 1; g < NREG; g++) begin : g_bit
    logic b;
    always_ff @(posedge clk or negedge reset) begin
      if (!reset)                                 b <= 1'b0;
      else if (set_en && set_idx == REG_W'(g))    b <= 1'b1;
      else if (clr_en && clr_idx == REG_W'(g))    b <= 1'b0;
    end
    assign busy[g] = b;
  end

  assign hit0 = busy[rd_idx0];
  assign hit1 = busy[rd_idx1];

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline stall/bubble/flush controller for a 5-stage pipe.
// Optional perf counters are built when PIPE_CTRL_PERF_EN is defined.
module pipe_ctrl
  import pipe_pkg::*;
#(
  parameter int NREG  = 32,
  parameter int REG_W = 5,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             if_busy,
  input  logic             id_valid,
  input  logic [REG_W-1:0] id_rs1,
  input  logic [REG_W-1:0] id_rs2,
  input  logic             id_use_rs1,
  input  logic             id_use_rs2,
  input  logic [REG_W-1:0] id_rd,
  input  logic             id_en_rd,
  input  logic             ex_branch_taken,
  input  logic             mem_req,
  input  logic             mem_done,
  input  logic             wb_valid,
  input  logic             wb_en_rd,
  input  logic [REG_W-1:0] wb_rd,
  output logic             pc_wr_en,
  output logic             if_id_wr_en,
  output logic             if_id_bubble,
  output logic             id_ex_wr_en,
  output logic             id_ex_bubble,
  output logic             ex_mem_wr_en,
  output logic             ex_mem_bubble,
  output logic             mem_wb_wr_en,
  output logic             mem_wb_bubble
`ifdef PIPE_CTRL_PERF_EN
  ,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_count
`endif
);

  ctrl_state_t                   state, state_nxt;
  stage_ctrl_t [NUM_STAGES-1:0]  stg;
  logic                          pc_en;
  logic                          mem_stall;
  logic                          flush;
  logic                          hit1, hit2;
  logic                          data_haz;
  logic                          sb_set;

  reg_scoreboard #(.NREG(NREG), .REG_W(REG_W)) u_sb (
    .clk     (clk),
    .reset   (reset),
    .set_en  (sb_set),
    .set_idx (id_rd),
    .clr_en  (wb_valid & wb_en_rd),
    .clr_idx (wb_rd),
    .rd_idx0 (id_rs1),
    .rd_idx1 (id_rs2),
    .hit0    (hit1),
    .hit1    (hit2)
  );

  assign data_haz = id_valid & ((id_use_rs1 & hit1) | (id_use_rs2 & hit2));

  // MEM_WAIT stalls until the completion pulse; a same-cycle completion in RUN is free.
  assign mem_stall = (state == MEM_WAIT) ? ~mem_done : (mem_req & ~mem_done);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= RUN;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    pc_en     = 1'b1;
    flush     = 1'b0;
    for (int s = 0; s < NUM_STAGES; s++) stg[s] = STG_ADV;

    case (state)
      RUN:      if (mem_req && !mem_done) state_nxt = MEM_WAIT;
      MEM_WAIT: if (mem_done)             state_nxt = RUN;
      default:                            state_nxt = RUN;
    endcase

    if (mem_stall) begin
      pc_en       = 1'b0;
      stg[IF_ID]  = STG_HOLD;
      stg[ID_EX]  = STG_HOLD;
      stg[EX_MEM] = STG_HOLD;
      stg[MEM_WB] = STG_BUB;
    end else if (ex_branch_taken) begin
      flush      = 1'b1;
      stg[IF_ID] = STG_BUB;
      stg[ID_EX] = STG_BUB;
    end else if (data_haz) begin
      pc_en      = 1'b0;
      stg[IF_ID] = STG_HOLD;
      stg[ID_EX] = STG_BUB;
    end else if (if_busy) begin
      pc_en      = 1'b0;
      stg[IF_ID] = STG_BUB;
    end

    // Outputs are combinational, so they must be forced while reset is held.
    if (!reset) begin
      pc_en = 1'b0;
      flush = 1'b0;
      for (int s = 0; s < NUM_STAGES; s++) stg[s] = STG_RST;
    end
  end

  assign sb_set = stg[ID_EX].wr_en & ~stg[ID_EX].bubble & id_valid & id_en_rd &
                  (id_rd != '0);

  assign pc_wr_en      = pc_en;
  assign if_id_wr_en   = stg[IF_ID].wr_en;
  assign if_id_bubble  = stg[IF_ID].bubble;
  assign id_ex_wr_en   = stg[ID_EX].wr_en;
  assign id_ex_bubble  = stg[ID_EX].bubble;
  assign ex_mem_wr_en  = stg[EX_MEM].wr_en;
  assign ex_mem_bubble = stg[EX_MEM].bubble;
  assign mem_wb_wr_en  = stg[MEM_WB].wr_en;
  assign mem_wb_bubble = stg[MEM_WB].bubble;

`ifdef PIPE_CTRL_PERF_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cycles <= '0;
      flush_count  <= '0;
    end else begin
      if (!pc_en && stall_cycles != '1) stall_cycles <= stall_cycles + 1'b1;
      if (flush && flush_count != '1)   flush_count  <= flush_count + 1'b1;
    end
  end
`else
  logic perf_unused;
  assign perf_unused = ^{flush, CNT_W};
`endif

endmodule

// File: doc/pipe_ctrl.md
# pipe_ctrl

Pipeline control unit that drives the `wr_en` / `gen_bubble` inputs of the four inter-stage registers (IF/ID, ID/EX, EX/MEM, MEM/WB) and the PC write enable. It detects read-after-write hazards with a register scoreboard, stalls on multi-cycle memory accesses, inserts a bubble while fetch is outstanding, and squashes younger instructions on a taken branch. It sits beside the datapath as the single source of stall, bubble and flush decisions.

## Interface
- `NREG`, 32: architectural register count; x0 is never tracked.
- `REG_W`, 5: register index width, equal to $clog2(NREG).
- `CNT_W`, 32: performance counter width; used only with `PIPE_CTRL_PERF_EN`.
- `clk`  in  1  clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-low reset (asserted at 0).
- `if_busy`  in  1  the fetch for the current PC is still outstanding.
- `id_valid`  in  1  ID holds a real instruction, not a bubble.
- `id_rs1`, `id_rs2`  in  REG_W  source register indices in ID.
- `id_use_rs1`, `id_use_rs2`  in  1  the ID instruction reads the matching source.
- `id_rd`  in  REG_W  destination register index in ID.
- `id_en_rd`  in  1  the ID instruction writes `id_rd`.
- `ex_branch_taken`  in  1  a valid EX instruction redirects the PC.
- `mem_req`  in  1  the MEM stage holds a valid load or store.
- `mem_done`  in  1  single-cycle pulse: the memory access completes.
- `wb_valid`, `wb_en_rd`  in  1  a WB instruction retires and writes `wb_rd`.
- `wb_rd`  in  REG_W  retiring destination register.
- `pc_wr_en`  out  1  PC may update.
- `if_id_wr_en`, `if_id_bubble`  out  1  enable and bubble for IF/ID.
- `id_ex_wr_en`, `id_ex_bubble`  out  1  enable and bubble for ID/EX.
- `ex_mem_wr_en`, `ex_mem_bubble`  out  1  enable and bubble for EX/MEM.
- `mem_wb_wr_en`, `mem_wb_bubble`  out  1  enable and bubble for MEM/WB.
- `stall_cycles`, `flush_count`  out  CNT_W  performance counters; present only with `PIPE_CTRL_PERF_EN`.

## Operation
- **FSM states:** RUN and MEM_WAIT. Reset enters RUN.
  - RUN → MEM_WAIT when `mem_req & ~mem_done`.
  - MEM_WAIT → RUN on `mem_done`.
  - A request that completes in zero wait cycles (`mem_req & mem_done` in RUN) causes no stall.
- **Priority, highest first:**
  1. Memory stall
  2. Branch flush
  3. Data hazard
  4. Fetch busy
  5. Normal advance (all `wr_en`=1, all bubbles 0)
- **Memory stall** applies in MEM_WAIT without `mem_done`, and in RUN with `mem_req & ~mem_done`.
  - `pc_wr_en`, `if_id_wr_en`, `id_ex_wr_en`, `ex_mem_wr_en` = 0.
  - `mem_wb_wr_en`=1 with `mem_wb_bubble`=1.
  - A taken branch held in EX stays asserted and is acted on in the release cycle.
- **Branch flush** (`ex_branch_taken`):
  - `pc_wr_en`=1.
  - IF/ID and ID/EX written with bubble=1.
  - EX/MEM and MEM/WB advance normally.
  - Any data hazard in the same cycle is ignored.
- **Data hazard:** `id_valid` and a used source register with its scoreboard bit set.
  - `pc_wr_en`=0 and `if_id_wr_en`=0.
  - ID/EX written with bubble=1; the rest advance.
- **Fetch busy:** `pc_wr_en`=0; IF/ID written with bubble=1; the rest advance.
- **Scoreboard:** NREG-1 bits.
  - Set bit `id_rd` when ID advances a real instruction: `id_ex_wr_en & ~id_ex_bubble & id_valid & id_en_rd & id_rd!=0`.
  - Clear bit `wb_rd` on `wb_valid & wb_en_rd`.
  - Set and clear of the same bit in the same cycle: set wins.
  - Hazard checks use the registered bits. The register file does not bypass, so a consumer waits one cycle past its producer's WB cycle.

## Timing
- All outputs are combinational from state, scoreboard and current inputs; decisions take effect at the next clock edge.
- **During reset:** all `wr_en`=0, all bubbles=1, scoreboard cleared, state RUN, counters 0.
- **Reset asserted mid-stall:** the state is abandoned immediately; no completion is awaited.
- **Minimum penalties:** load-use 3 bubble cycles (EX, MEM, WB drain); taken branch 2 squashed slots; zero-wait memory 0 cycles.

## Configuration
- `PIPE_CTRL_PERF_EN` defined:
  - `stall_cycles` increments on every cycle with `pc_wr_en`=0 (reset excluded).
  - `flush_count` increments once per cycle in which a branch flush is applied.
  - Both counters saturate at all-ones.
- Undefined: the counter ports and logic are absent; control behaviour is identical.

## Structure
- Package `pipe_pkg` holds:
  - `ctrl_state_t` enum {RUN, MEM_WAIT}.
  - `stage_ctrl_t` packed struct {wr_en, bubble}.
  - Stage index constants IF_ID, ID_EX, EX_MEM, MEM_WB.
- Sub-module `reg_scoreboard` holds the set/clear bitmask and exposes two read ports returning hit bits.

## Test plan
- **Back-to-back dependency:** `addi x5` then `add x6,x5,x5`, no memory stalls → ID/EX bubble for exactly 3 cycles after x5 is issued; the consumer advances the cycle after WB retires x5.
- **Load miss:** `mem_req`=1 with `mem_done` 4 cycles later → `pc_wr_en`=0 and `mem_wb_bubble`=1 for 4 cycles; all `wr_en`=1 in the `mem_done` cycle.
- **Branch during memory stall:** `ex_branch_taken`=1 during a 2-cycle memory stall → no flush while stalled; IF/ID and ID/EX bubbles applied in the release cycle; `flush_count`=1.
- **Same-cycle set/clear:** ID writes x7 while WB retires x7 → scoreboard bit 7 remains set.
- **x0 destination:** `id_rd`=0 with `id_en_rd`=1 → no scoreboard bit set; a following x0 reader never stalls.
- **Reset mid-stall:** `reset` pulled low in MEM_WAIT with scoreboard 0x20 → outputs go to reset values at once; after release, state is RUN and the scoreboard reads 0.
